mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between the fetch stage (read-only) and the MEM stage (loads and stores).
- Arbitrates between the two requesters and sequences each access through issue, wait and respond.
- Generates byte enables and replicated write data from the store width code (swhb).
- Load byte/half extraction and sign extension remain in the MEM stage.

---
 rtl/mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port, fixed-latency memory between the fetch stage
//   (read-only) and the MEM stage (loads and stores). It serves one access
//   at a time through ISSUE -> (WAIT) -> DONE. Store byte enables and the
//   replicated write lanes are built here. Load byte/half extraction and
//   sign extension stay in the MEM stage.
//
// Ports
//   clk, reset       clock (rising edge), synchronous active-low reset
//   if_req/if_addr   fetch request, held until if_ready
//   if_ready/if_rdata  one-cycle completion pulse, fetched word
//   d_req/d_we/d_addr/d_wdata/d_swhb  data request, held until d_ready
//   d_ready/d_rdata  one-cycle completion pulse, raw loaded word
//   mem_*            memory strobe, write enable, word address, lanes, rdata
//   busy             arbiter is not idle
//
// State table
//   IDLE  | arbitrate; latch the winning request
//   ISSUE | drive mem_en for exactly one cycle
//   WAIT  | count down MEM_LAT cycles, capture mem_rdata on the last one
//   DONE  | pulse the owner's ready, return to IDLE

module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [1:0]            d_swhb,
  output logic                  d_ready,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic       OWN_FETCH  = 1'b0;
  localparam logic       OWN_DATA   = 1'b1;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [3:0]            streak_q, streak_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  if_ready_q, if_ready_d;
  logic                  d_ready_q, d_ready_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  busy_q, busy_d;

  logic                  grant_data;
  logic                  grant_fetch;
  logic [3:0]            st_be;
  logic [DATA_WIDTH-1:0] st_wdata;

  // Fetches are always word aligned; the low address bits carry no meaning.
  logic                  if_addr_unused;
  assign if_addr_unused = ^if_addr[1:0];

  // Store lanes: the right-aligned store value is replicated across the
  // word so the enabled byte lanes always see the correct bits.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = d_wdata;
    case (d_swhb)
      2'b10: begin
        st_be    = d_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{d_wdata[15:0]}};
      end
      2'b11: begin
        st_be    = 4'b0001 << d_addr[1:0];
        st_wdata = {4{d_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Data wins unless fetch is also waiting and data has already taken
  // STARVE_MAX contended grants in a row.
  assign grant_data  = d_req && (!if_req || (streak_q < STARVE_LIM));
  assign grant_fetch = if_req && !grant_data;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    owner_d     = owner_q;
    we_d        = we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_be_d    = 4'b0000;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_data) begin
          owner_d    = OWN_DATA;
          we_d       = d_we;
          mem_en_d   = 1'b1;
          mem_we_d   = d_we;
          mem_addr_d = {d_addr[ADDR_WIDTH-1:2], 2'b00};
          if (d_we) begin
            mem_be_d    = st_be;
            mem_wdata_d = st_wdata;
          end else begin
            mem_be_d    = 4'b1111;
            mem_wdata_d = '0;
          end
          // Only contended grants count; the grant rule keeps this <= limit.
          if (if_req) begin
            streak_d = streak_q + 4'd1;
          end
          state_d = ISSUE;
        end else if (grant_fetch) begin
          owner_d     = OWN_FETCH;
          we_d        = 1'b0;
          mem_en_d    = 1'b1;
          mem_addr_d  = {if_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_be_d    = 4'b1111;
          mem_wdata_d = '0;
          streak_d    = 4'd0;
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        if (we_q) begin
          // Posted write: nothing comes back, complete immediately.
          d_ready_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = WAIT;
        end
      end

      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          if (owner_q == OWN_DATA) begin
            d_rdata_d = mem_rdata;
            d_ready_d = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      streak_q    <= 4'd0;
      owner_q     <= OWN_FETCH;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign d_ready   = d_ready_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. The main instance uses MEM_LAT=2,
// STARVE_MAX=4; a second instance uses MEM_LAT=1 for back-to-back loads.
// Each memory model returns a word only in the cycle it is due and junk
// in every other cycle, so latency slips show up as wrong rdata.

module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_swhb;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        busy;

  logic        l1_if_req;
  logic [31:0] l1_if_addr;
  logic        l1_if_ready;
  logic [31:0] l1_if_rdata;
  logic        l1_d_req;
  logic        l1_d_we;
  logic [31:0] l1_d_addr;
  logic [31:0] l1_d_wdata;
  logic [1:0]  l1_d_swhb;
  logic        l1_d_ready;
  logic [31:0] l1_d_rdata;
  logic        l1_mem_en;
  logic        l1_mem_we;
  logic [31:0] l1_mem_addr;
  logic [31:0] l1_mem_wdata;
  logic [3:0]  l1_mem_be;
  logic [31:0] l1_mem_rdata;
  logic        l1_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int if_ready_cnt = 0;
  int both_ready_cnt = 0;

  mem_port_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_swhb(d_swhb),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u_dut_l1 (
    .clk(clk), .reset(reset),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_ready(l1_if_ready), .if_rdata(l1_if_rdata),
    .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
    .d_swhb(l1_d_swhb), .d_ready(l1_d_ready), .d_rdata(l1_d_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_be(l1_mem_be), .mem_rdata(l1_mem_rdata),
    .busy(l1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hDEAD_BEEF;
      32'h0000_0104: return 32'h0BAD_F00D;
      32'h0000_0300: return 32'h1111_2222;
      32'h0000_0304: return 32'h3333_4444;
      32'h0000_0308: return 32'h5555_6666;
      default:       return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  // Latency-2 memory: word appears exactly two cycles after the mem_en cycle.
  logic [31:0] stage_rd;
  always @(posedge clk) begin
    stage_rd  <= (mem_en && !mem_we) ? mem_word(mem_addr) : 32'hBADC_0DE0;
    mem_rdata <= stage_rd;
    l1_mem_rdata <= (l1_mem_en && !l1_mem_we) ? mem_word(l1_mem_addr) : 32'hBADC_0DE1;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (if_ready) if_ready_cnt++;
    if (if_ready && d_ready) both_ready_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0: return if_ready;
      1: return d_ready;
      2: return mem_en;
      3: return l1_d_ready;
      default: return l1_mem_en;
    endcase
  endfunction

  // Advance until the chosen signal is high; waited = cycles advanced.
  task automatic wait_sig(input int which, input string tag, output int waited);
    waited = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      waited++;
      if (sig_of(which)) return;
    end
    check_val({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic do_store(input string tag, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sw, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_a);
    int w;
    d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = wd; d_swhb = sw;
    wait_sig(2, {tag, "_en"}, w);
    check_val({tag, "_en_lat"}, 32'(w), 32'd1);
    check_val({tag, "_be"}, {28'd0, mem_be}, {28'd0, exp_be});
    check_val({tag, "_wdata"}, mem_wdata, exp_wd);
    check_val({tag, "_addr"}, mem_addr, exp_a);
    check_val({tag, "_we"}, {31'd0, mem_we}, 32'd1);
    wait_sig(1, {tag, "_rdy"}, w);
    check_val({tag, "_rdy_lat"}, 32'(w), 32'd1);
    d_req = 1'b0;
    tick();
  endtask

  logic [31:0] exp_order [6];
  int          en_cyc [3];

  initial begin
    int w;
    int cnt0;
    logic [31:0] l1_addrs [3];
    logic [31:0] l1_data [3];

    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_swhb = 2'b01;
    l1_if_req = 1'b0; l1_if_addr = '0;
    l1_d_req = 1'b0; l1_d_we = 1'b0; l1_d_addr = '0; l1_d_wdata = '0; l1_d_swhb = 2'b01;
    tick(); tick(); tick();
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check_val("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check_val("rst_if_rdata", if_rdata, 32'd0);
    check_val("rst_d_rdata", d_rdata, 32'd0);
    reset = 1'b1;
    tick();

    // 1: single fetch, MEM_LAT=2
    if_req = 1'b1; if_addr = 32'h100;
    wait_sig(2, "t1_en", w);
    check_val("t1_en_lat", 32'(w), 32'd1);
    check_val("t1_addr", mem_addr, 32'h100);
    check_val("t1_be", {28'd0, mem_be}, 32'hF);
    check_val("t1_we", {31'd0, mem_we}, 32'd0);
    wait_sig(0, "t1_rdy", w);
    check_val("t1_rdy_lat", 32'(w), 32'd3);
    check_val("t1_rdata", if_rdata, 32'hDEAD_BEEF);
    if_req = 1'b0;
    tick();
    check_val("t1_rdy_pulse", {31'd0, if_ready}, 32'd0);
    check_val("t1_idle_be", {28'd0, mem_be}, 32'd0);

    // 2: store lanes
    do_store("t2_b203", 32'h203, 32'h0000_00A5, 2'b11, 4'b1000, 32'hA5A5_A5A5, 32'h200);
    do_store("t2_h202", 32'h202, 32'hFFFF_1234, 2'b10, 4'b1100, 32'h1234_1234, 32'h200);
    do_store("t2_b201", 32'h201, 32'h0000_003C, 2'b11, 4'b0010, 32'h3C3C_3C3C, 32'h200);
    do_store("t2_h201", 32'h201, 32'h0000_ABCD, 2'b10, 4'b0011, 32'hABCD_ABCD, 32'h200);
    do_store("t2_w00", 32'h20A, 32'hCAFE_F00D, 2'b00, 4'b1111, 32'hCAFE_F00D, 32'h208);

    // 3: contention; data stores to 0x500, fetch from 0x400
    exp_order = '{32'h500, 32'h500, 32'h500, 32'h500, 32'h400, 32'h500};
    if_req = 1'b1; if_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h500; d_wdata = 32'h7; d_swhb = 2'b01;
    for (int g = 0; g < 6; g++) begin
      wait_sig(2, "t3_en", w);
      check_val($sformatf("t3_grant%0d", g), mem_addr, exp_order[g]);
    end
    wait_sig(1, "t3_last_rdy", w);
    if_req = 1'b0; d_req = 1'b0;
    tick();
    check_val("t3_if_rdata", if_rdata, 32'hC0DE_0400);

    // 4: simultaneous first request after reset, data load wins
    reset = 1'b0; tick(); reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    wait_sig(2, "t4_en_d", w);
    check_val("t4_first", mem_addr, 32'h300);
    wait_sig(1, "t4_drdy", w);
    check_val("t4_drdy_lat", 32'(w), 32'd3);
    check_val("t4_no_ifrdy", {31'd0, if_ready}, 32'd0);
    check_val("t4_d_rdata", d_rdata, 32'h1111_2222);
    d_req = 1'b0;
    wait_sig(2, "t4_en_f", w);
    check_val("t4_second", mem_addr, 32'h104);
    check_val("t4_f_gap", 32'(w), 32'd2);
    wait_sig(0, "t4_ifrdy", w);
    check_val("t4_ifrdy_lat", 32'(w), 32'd3);
    check_val("t4_if_rdata", if_rdata, 32'h0BAD_F00D);
    if_req = 1'b0;
    tick();

    // 5: reset during WAIT abandons the read
    if_req = 1'b1; if_addr = 32'h100;
    wait_sig(2, "t5_en", w);
    tick();
    check_val("t5_busy_wait", {31'd0, busy}, 32'd1);
    reset = 1'b0; if_req = 1'b0;
    cnt0 = if_ready_cnt;
    tick();
    check_val("t5_busy", {31'd0, busy}, 32'd0);
    check_val("t5_mem_en", {31'd0, mem_en}, 32'd0);
    check_val("t5_if_rdata", if_rdata, 32'd0);
    tick();
    reset = 1'b1;
    tick(); tick(); tick();
    check_val("t5_no_rdy", 32'(if_ready_cnt - cnt0), 32'd0);
    if_req = 1'b1; if_addr = 32'h104;
    wait_sig(2, "t5_en2", w);
    check_val("t5_en2_lat", 32'(w), 32'd1);
    wait_sig(0, "t5_rdy2", w);
    check_val("t5_rdy2_lat", 32'(w), 32'd3);
    check_val("t5_rdata2", if_rdata, 32'h0BAD_F00D);
    if_req = 1'b0;
    tick();

    // 6: MEM_LAT=1 back-to-back loads, d_req held
    l1_addrs = '{32'h300, 32'h304, 32'h308};
    l1_data  = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
    l1_d_req = 1'b1; l1_d_we = 1'b0; l1_d_addr = l1_addrs[0];
    for (int k = 0; k < 3; k++) begin
      wait_sig(4, "t6_en", w);
      en_cyc[k] = cyc;
      check_val($sformatf("t6_addr%0d", k), l1_mem_addr, l1_addrs[k]);
      wait_sig(3, "t6_rdy", w);
      check_val($sformatf("t6_rdy_lat%0d", k), 32'(w), 32'd2);
      check_val($sformatf("t6_rdata%0d", k), l1_d_rdata, l1_data[k]);
      if (k < 2) l1_d_addr = l1_addrs[k+1];
    end
    l1_d_req = 1'b0;
    check_val("t6_gap01", 32'(en_cyc[1] - en_cyc[0]), 32'd4);
    check_val("t6_gap12", 32'(en_cyc[2] - en_cyc[1]), 32'd4);
    tick(); tick();

    check_val("both_ready", 32'(both_ready_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
